// File: rtl/simple_ram_fill_writer_pkg.sv
// Shared FSM state encoding for the RAM fill writer.
package simple_ram_fill_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_VERIFY = 2'd2,
        ST_TAIL   = 2'd3
    } state_e;

endpackage

// File: rtl/simple_biclk_bidir_ram.sv
// Dual-clock RAM: port A read/write on clk, port B read-only on clk2; one-cycle registered reads.
// A same-cycle write on port A returns the old word on q_a.
module simple_biclk_bidir_ram #(
    parameter int width   = 8,
    parameter int widthad = 10
) (
    input  logic               clk,
    input  logic               clk2,
    input  logic [widthad-1:0] address_a,
    input  logic               wren_a,
    input  logic [width-1:0]   data_a,
    output logic [width-1:0]   q_a,
    input  logic [widthad-1:0] address_b,
    output logic [width-1:0]   q_b
);

    logic [width-1:0] mem_q [2**widthad];

    always_ff @(posedge clk) begin
        if (wren_a) begin
            mem_q[address_a] <= data_a;
        end
        q_a <= mem_q[address_a];
    end

    always_ff @(posedge clk2) begin
        q_b <= mem_q[address_b];
    end

endmodule

// File: rtl/simple_ram_fill_writer.sv
// Streams count words into RAM port A from base_addr (wrapping), reads them back and compares XOR checksums.
// Latency with no stalls: done 2*count+2 cycles after start; in_ready only in WRITE, stalls hold the pointer.
module simple_ram_fill_writer
    import simple_ram_fill_writer_pkg::*;
#(
    parameter int width   = 8,
    parameter int widthad = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [widthad-1:0] base_addr,
    input  logic [widthad:0]   count,
    output logic               busy,
    output logic               done,
    output logic               error,
    input  logic               in_valid,
    input  logic [width-1:0]   in_data,
    output logic               in_ready,
    output logic [widthad-1:0] address_a,
    output logic               wren_a,
    output logic [width-1:0]   data_a,
    input  logic [width-1:0]   q_a
);

    localparam logic [widthad:0] DEPTH = {1'b1, {widthad{1'b0}}};
    localparam logic [widthad:0] ONE   = {{widthad{1'b0}}, 1'b1};

    state_e             state_q;
    logic [widthad-1:0] ptr_q;
    logic [widthad-1:0] base_q;
    logic [widthad:0]   cnt_q;
    logic [widthad:0]   rem_q;
    logic [width-1:0]   wr_sum_q;
    logic [width-1:0]   rd_sum_q;
    logic               rd_pend_q;
    logic               done_q;
    logic               error_q;
    logic [widthad-1:0] addr_hold_q;
    logic [width-1:0]   data_hold_q;
    logic [widthad:0]   count_d;

    assign count_d = (count > DEPTH) ? DEPTH : count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            base_q      <= '0;
            cnt_q       <= '0;
            rem_q       <= '0;
            wr_sum_q    <= '0;
            rd_sum_q    <= '0;
            rd_pend_q   <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            addr_hold_q <= '0;
            data_hold_q <= '0;
        end else begin
            done_q    <= 1'b0;
            rd_pend_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        error_q <= 1'b0;
                        if (count_d == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            ptr_q    <= base_addr;
                            base_q   <= base_addr;
                            cnt_q    <= count_d;
                            rem_q    <= count_d;
                            wr_sum_q <= '0;
                            rd_sum_q <= '0;
                            state_q  <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (in_valid) begin
                        addr_hold_q <= ptr_q;
                        data_hold_q <= in_data;
                        wr_sum_q    <= wr_sum_q ^ in_data;
                        if (rem_q == ONE) begin
                            ptr_q   <= base_q;
                            rem_q   <= cnt_q;
                            state_q <= ST_VERIFY;
                        end else begin
                            ptr_q <= ptr_q + 1'b1;
                            rem_q <= rem_q - 1'b1;
                        end
                    end
                end
                ST_VERIFY: begin
                    // Read data lags its address by one cycle, so accumulate the previous read.
                    addr_hold_q <= ptr_q;
                    ptr_q       <= ptr_q + 1'b1;
                    rem_q       <= rem_q - 1'b1;
                    rd_pend_q   <= 1'b1;
                    if (rd_pend_q) begin
                        rd_sum_q <= rd_sum_q ^ q_a;
                    end
                    if (rem_q == ONE) begin
                        state_q <= ST_TAIL;
                    end
                end
                ST_TAIL: begin
                    error_q <= ((rd_sum_q ^ q_a) != wr_sum_q);
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign error     = error_q;
    assign in_ready  = (state_q == ST_WRITE) && !rst;
    assign wren_a    = in_ready && in_valid;
    assign address_a = (state_q == ST_WRITE || state_q == ST_VERIFY) ? ptr_q : addr_hold_q;
    assign data_a    = (state_q == ST_WRITE) ? in_data : data_hold_q;

endmodule
